// File: rtl/bist_response_analyzer.sv
// -----------------------------------------------------------------------------
// bist_response_analyzer
//   Downstream stage of the BIST datapath. It sequences the scan chain
//   (shift / capture), compacts every response bit leaving the chain into a
//   serial-input signature register (SISR), and finally compares the
//   signature against a golden value. One start pulse runs a complete test.
//
//   Optional feature: define BIST_ANALYZER_ABORT_EN to add the abort input,
//   which returns a running test to IDLE without reporting a result.
//
// Ports
//   clk        in   1          clock, rising edge
//   rst_n      in   1          synchronous, active-low reset
//   start      in   1          begin a run (ignored while busy)
//   abort      in   1          (BIST_ANALYZER_ABORT_EN only) cancel a run
//   scan_out   in   1          serial response bit from the chain MSB
//   golden     in   SIG_WIDTH  expected signature, sampled in COMPARE
//   scan_en    out  1          1 = chain shifts, 0 = chain holds/captures
//   busy       out  1          run in progress (SHIFT/CAPTURE/COMPARE)
//   done       out  1          run finished, held until next start/reset
//   pass       out  1          valid with done: signature == golden
//   signature  out  SIG_WIDTH  current SISR contents
// -----------------------------------------------------------------------------
module bist_response_analyzer #(
  parameter int                   CHAIN_LEN    = 8,
  parameter int                   NUM_PATTERNS = 16,
  parameter int                   SIG_WIDTH    = 8,
  parameter logic [SIG_WIDTH-1:0] SIG_POLY     = SIG_WIDTH'(8'h1D)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
`ifdef BIST_ANALYZER_ABORT_EN
  input  logic                 abort,
`endif
  input  logic                 scan_out,
  input  logic [SIG_WIDTH-1:0] golden,
  output logic                 scan_en,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [SIG_WIDTH-1:0] signature
);

  localparam int BIT_W = $clog2(CHAIN_LEN + 1);
  localparam int PAT_W = $clog2(NUM_PATTERNS + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SHIFT   = 3'd1,
    S_CAPTURE = 3'd2,
    S_COMPARE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [PAT_W-1:0]     pat_cnt_q, pat_cnt_d;
  logic [SIG_WIDTH-1:0] sig_q, sig_d;
  logic                 pass_q, pass_d;

  logic                 run_active;
  logic                 launch;
  logic                 last_bit;
  logic                 abort_hit;

  // One SISR step: shift left, fold the MSB back through the polynomial,
  // and inject the incoming response bit at bit 0.
  function automatic logic [SIG_WIDTH-1:0] sisr_step(
    input logic [SIG_WIDTH-1:0] s,
    input logic                 b
  );
    sisr_step = {s[SIG_WIDTH-2:0], 1'b0}
              ^ (s[SIG_WIDTH-1] ? SIG_POLY : '0)
              ^ {{(SIG_WIDTH-1){1'b0}}, b};
  endfunction

  assign run_active = (state_q == S_SHIFT) || (state_q == S_CAPTURE) ||
                      (state_q == S_COMPARE);
  assign launch     = ((state_q == S_IDLE) || (state_q == S_DONE)) && start;
  assign last_bit   = (bit_cnt_q == BIT_W'(CHAIN_LEN - 1));

`ifdef BIST_ANALYZER_ABORT_EN
  assign abort_hit  = abort && run_active;
`else
  assign abort_hit  = 1'b0;
`endif

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      pat_cnt_q <= '0;
      sig_q     <= '0;
      pass_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      pat_cnt_q <= pat_cnt_d;
      sig_q     <= sig_d;
      pass_q    <= pass_d;
    end
  end

  // Next-state logic; abort overrides everything, including a same-edge start
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE: if (start) state_d = S_SHIFT;
      S_SHIFT: begin
        if (last_bit) begin
          state_d = (pat_cnt_q < PAT_W'(NUM_PATTERNS)) ? S_CAPTURE : S_COMPARE;
        end
      end
      S_CAPTURE: state_d = S_SHIFT;
      S_COMPARE: state_d = S_DONE;
      default:   state_d = S_IDLE;
    endcase
    if (abort_hit) state_d = S_IDLE;
  end

  // Counter / signature / verdict next values
  always_comb begin
    bit_cnt_d = bit_cnt_q;
    pat_cnt_d = pat_cnt_q;
    sig_d     = sig_q;
    pass_d    = pass_q;
    if (abort_hit) begin
      // Signature is kept for inspection; counters restart on the next launch.
      bit_cnt_d = '0;
      pat_cnt_d = '0;
      pass_d    = 1'b0;
    end else if (launch) begin
      bit_cnt_d = '0;
      pat_cnt_d = '0;
      sig_d     = '0;
      pass_d    = 1'b0;
    end else begin
      unique case (state_q)
        S_SHIFT: begin
          bit_cnt_d = last_bit ? '0 : bit_cnt_q + 1'b1;
          // The first unload window only preloads the chain; what comes out
          // is stale content from before the run and must not be compacted.
          if (pat_cnt_q != '0) sig_d = sisr_step(sig_q, scan_out);
        end
        S_CAPTURE: pat_cnt_d = pat_cnt_q + 1'b1;
        S_COMPARE: pass_d    = (sig_q == golden);
        default: ;
      endcase
    end
  end

  // Moore outputs
  always_comb begin
    scan_en   = (state_q == S_SHIFT);
    busy      = run_active;
    done      = (state_q == S_DONE);
    pass      = pass_q;
    signature = sig_q;
  end

endmodule

// File: tb/tb_bist_response_analyzer.sv
module tb_bist_response_analyzer;

  localparam int CL       = 8;
  localparam int NP_SMALL = 1;
  localparam int NP_BIG   = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic       scan_out;
  logic [7:0] golden;

  logic       s_scan_en, s_busy, s_done, s_pass;
  logic [7:0] s_sig;
  logic       b_scan_en, b_busy, b_done, b_pass;
  logic [7:0] b_sig;

  logic       sel;  // 0: small instance (1 pattern), 1: default instance
  logic       o_scan_en, o_busy, o_done, o_pass;
  logic [7:0] o_sig;

  int total = 0;
  int bad   = 0;

  logic stream [0:255];
  logic [7:0] gold_ref;

  always #5 clk = ~clk;

  bist_response_analyzer #(.CHAIN_LEN(CL), .NUM_PATTERNS(NP_SMALL)) u_small (
    .clk(clk), .rst_n(rst_n), .start(start),
`ifdef BIST_ANALYZER_ABORT_EN
    .abort(abort),
`endif
    .scan_out(scan_out), .golden(golden),
    .scan_en(s_scan_en), .busy(s_busy), .done(s_done), .pass(s_pass), .signature(s_sig)
  );

  bist_response_analyzer #(.CHAIN_LEN(CL), .NUM_PATTERNS(NP_BIG)) u_big (
    .clk(clk), .rst_n(rst_n), .start(start),
`ifdef BIST_ANALYZER_ABORT_EN
    .abort(abort),
`endif
    .scan_out(scan_out), .golden(golden),
    .scan_en(b_scan_en), .busy(b_busy), .done(b_done), .pass(b_pass), .signature(b_sig)
  );

  assign o_scan_en = sel ? b_scan_en : s_scan_en;
  assign o_busy    = sel ? b_busy    : s_busy;
  assign o_done    = sel ? b_done    : s_done;
  assign o_pass    = sel ? b_pass    : s_pass;
  assign o_sig     = sel ? b_sig     : s_sig;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Cycle k (the cycle before edge E0+k, start sampled at E0) is a shift
  // cycle if it falls inside one of the np+1 unload windows of CL cycles,
  // each of the first np followed by a single capture cycle.
  function automatic logic is_shift(input int np, input int k);
    if (k <= np * (CL + 1)) return ((k - 1) % (CL + 1)) < CL;
    return k <= np * (CL + 1) + CL;
  endfunction

  // Signature over all response bits that come out after the first unload
  // window, for edges strictly before 'upto'.
  function automatic logic [7:0] model_sig(input int np, input int upto);
    logic [7:0] s = 8'h00;
    for (int k = CL + 2; k <= np * (CL + 1) + CL; k++) begin
      if (k < upto && is_shift(np, k)) begin
        s = {s[6:0], 1'b0} ^ (s[7] ? 8'h1D : 8'h00) ^ {7'd0, stream[k]};
      end
    end
    return s;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic chk_idle(input string tag, input logic [7:0] sig_exp);
    chk({tag, "/scan_en"}, o_scan_en, 1'b0);
    chk({tag, "/busy"},    o_busy,    1'b0);
    chk({tag, "/done"},    o_done,    1'b0);
    chk({tag, "/pass"},    o_pass,    1'b0);
    chk({tag, "/sig"},     o_sig,     sig_exp);
  endtask

  // One run from an accepted start. rst_k / abort_k: cycle at whose closing
  // edge reset / abort is applied (0 = never). mid_k: cycle with a stray start.
  task automatic run(input string tag, input int np, input int rst_k, input int abort_k,
                     input int mid_k, input logic exp_pass);
    int last_k;
    last_k = np * (CL + 1) + CL + 1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= last_k; k++) begin
      chk({tag, "/scan_en"}, o_scan_en, is_shift(np, k));
      chk({tag, "/busy"},    o_busy,    1'b1);
      chk({tag, "/done"},    o_done,    1'b0);
      scan_out = stream[k];
      start    = (k == mid_k) || (k == abort_k);
      abort    = (k == abort_k);
      if (k == rst_k) rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      start = 1'b0;
      abort = 1'b0;
      if (k == rst_k) begin
        chk_idle({tag, "/after_rst"}, 8'h00);
        return;
      end
      if (k == abort_k) begin
        chk_idle({tag, "/after_abort"}, model_sig(np, k));
        return;
      end
    end
    chk({tag, "/done_end"},    o_done,    1'b1);
    chk({tag, "/busy_end"},    o_busy,    1'b0);
    chk({tag, "/scan_en_end"}, o_scan_en, 1'b0);
    chk({tag, "/sig_end"},     o_sig,     model_sig(np, last_k + 1));
    chk({tag, "/pass_end"},    o_pass,    exp_pass);
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b1;
    abort    = 1'b0;
    scan_out = 1'b0;
    golden   = 8'h00;
    sel      = 1'b1;

    // Reset held two cycles with start asserted
    step();
    step();
    chk_idle("reset_big", 8'h00);
    sel = 1'b0;
    chk_idle("reset_small", 8'h00);
    rst_n = 1'b1;
    start = 1'b0;
    step();
    chk_idle("reset_hold", 8'h00);

    // Single pattern, response all ones: signature 8'hFF
    for (int i = 0; i < 256; i++) stream[i] = 1'b1;
    golden = 8'hFF;
    run("ones", NP_SMALL, 0, 0, 0, 1'b1);
    chk("ones/sig_const", o_sig, 8'hFF);

    // Single pattern, response all zeros against a non-zero golden
    do_reset();
    for (int i = 0; i < 256; i++) stream[i] = 1'b0;
    golden = 8'h01;
    run("zeros", NP_SMALL, 0, 0, 0, 1'b0);
    chk("zeros/sig_const", o_sig, 8'h00);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("zeros/done_held", o_done, 1'b1);
      chk("zeros/sig_frozen", o_sig, 8'h00);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    chk("zeros/restart_done", o_done, 1'b0);
    chk("zeros/restart_busy", o_busy, 1'b1);

    // Default configuration with random response stream
    do_reset();
    sel = 1'b1;
    for (int i = 0; i < 256; i++) stream[i] = 1'($urandom_range(0, 1));
    gold_ref = model_sig(NP_BIG, 1000);
    golden   = gold_ref;
    run("rand", NP_BIG, 0, 0, 0, 1'b1);
    chk("rand/sig_golden", o_sig, gold_ref);

    // Same stream with one compacted response bit flipped
    do_reset();
    stream[20] = ~stream[20];
    run("flip", NP_BIG, 0, 0, 0, 1'b0);
    stream[20] = ~stream[20];

    // Stray start mid-run must not disturb length or signature
    do_reset();
    run("midstart", NP_BIG, 0, 0, 40, 1'b1);
    chk("midstart/sig_golden", o_sig, gold_ref);

    // Reset at the capture edge that ends pattern 5, then a clean rerun
    do_reset();
    run("rst_mid", NP_BIG, 6 * (CL + 1), 0, 0, 1'b0);
    run("rerun", NP_BIG, 0, 0, 0, 1'b1);
    chk("rerun/sig_golden", o_sig, gold_ref);

`ifdef BIST_ANALYZER_ABORT_EN
    // Abort during shift of pattern 3 with start on the same edge
    do_reset();
    run("abort", NP_BIG, 0, 3 * (CL + 1) + 3, 0, 1'b0);
    step();
    chk_idle("abort_stay", model_sig(NP_BIG, 3 * (CL + 1) + 3));
    run("post_abort", NP_BIG, 0, 0, 0, 1'b1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
